// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, sequential/redirect fetch,
// IF/ID capture, EBREAK halt, misalignment flag and fetch counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] HALT_INST = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] inst_in,
  output logic [31:0] pc_out,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_inst,
  output logic        halted,
  output logic        misalign_err,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_e;

  localparam logic [31:0] PC_SPAN = 32'(MEM_WORDS * 4);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic [31:0] inst_q, inst_d;
  logic        halted_q, halted_d;
  logic        mis_q, mis_d;
  logic [15:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] pc_seq;
  logic [15:0] cnt_inc;
  logic        is_halt;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    pc_seq   = pc_plus4 % PC_SPAN;
    cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    is_halt  = (inst_in == HALT_INST);
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    ipc_d    = ipc_q;
    ipc4_d   = ipc4_q;
    inst_d   = inst_q;
    halted_d = halted_q;
    mis_d    = mis_q;
    cnt_d    = cnt_q;
    // Redirect outranks stall and every state.
    if (redirect_valid) begin
      pc_d     = {redirect_target[31:2], 2'b00};
      valid_d  = 1'b0;
      halted_d = 1'b0;
      state_d  = S_RUN;
      if (redirect_target[1:0] != 2'b00) begin
        mis_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_BOOT: begin
          valid_d = 1'b0;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (!stall) begin
            valid_d = 1'b1;
            ipc_d   = pc_q;
            ipc4_d  = pc_plus4;
            inst_d  = inst_in;
            cnt_d   = cnt_inc;
            if (is_halt) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end else begin
              pc_d = pc_seq;
            end
          end
        end
        S_HALT: begin
          valid_d = 1'b0;
        end
        default: begin
          state_d = S_BOOT;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      ipc_q    <= 32'd0;
      ipc4_q   <= 32'd0;
      inst_q   <= 32'd0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      ipc_q    <= ipc_d;
      ipc4_q   <= ipc4_d;
      inst_q   <= inst_d;
      halted_q <= halted_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pc_out       = pc_q;
  assign ifid_valid   = valid_q;
  assign ifid_pc      = ipc_q;
  assign ifid_pc4     = ipc4_q;
  assign ifid_inst    = inst_q;
  assign halted       = halted_q;
  assign misalign_err = mis_q;
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized run
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] HALT = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] inst_in;
  logic [31:0] pc_out;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_inst;
  logic        halted;
  logic        misalign_err;
  logic [15:0] fetch_count;

  logic [31:0] mem [64];

  int errors = 0;
  int checks = 0;

  // model state
  logic [31:0] m_pc;
  logic        m_v, m_halt, m_mis, m_boot;
  logic [31:0] m_ipc, m_ipc4, m_inst;
  int          m_cnt;

  always #5 clk = ~clk;

  assign inst_in = mem[(pc_out >> 2) % 64];

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .inst_in(inst_in), .pc_out(pc_out),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
    .ifid_pc4(ifid_pc4), .ifid_inst(ifid_inst),
    .halted(halted), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  task automatic model_edge(input logic r, input logic s,
                            input logic rv, input logic [31:0] t);
    logic [31:0] w;
    if (r) begin
      m_pc = 0; m_v = 0; m_ipc = 0; m_ipc4 = 0; m_inst = 0;
      m_halt = 0; m_mis = 0; m_cnt = 0; m_boot = 1;
    end else if (rv) begin
      m_pc = t & ~32'd3;
      m_v = 0; m_halt = 0; m_boot = 0;
      if (t[1:0] != 0) m_mis = 1;
    end else if (m_boot) begin
      m_v = 0; m_boot = 0;
    end else if (m_halt) begin
      m_v = 0;
    end else if (!s) begin
      w = mem[(m_pc >> 2) % 64];
      m_v = 1; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_inst = w;
      if (m_cnt < 65535) m_cnt++;
      if (w == HALT) m_halt = 1;
      else m_pc = (m_pc + 4) % 256;
    end
  endtask

  task automatic tick(input logic r, input logic s,
                      input logic rv, input logic [31:0] t);
    rst = r; stall = s; redirect_valid = rv; redirect_target = t;
    model_edge(r, s, rv, t);
    @(posedge clk);
    #1;
    rst = 0; stall = 0; redirect_valid = 0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
  endtask

  task automatic test_reset();
    load_ramp();
    tick(1, 1, 1, 32'h42);
    checks++;
    if (pc_out !== 32'd0 || ifid_valid !== 1'b0 || halted !== 1'b0 ||
        misalign_err !== 1'b0 || fetch_count !== 16'd0 ||
        ifid_pc !== 32'd0 || ifid_pc4 !== 32'd0 || ifid_inst !== 32'd0) begin
      errors++;
      $display("FAIL reset: pc=%h v=%b h=%b mis=%b cnt=%0d ipc=%h want all zero",
               pc_out, ifid_valid, halted, misalign_err, fetch_count, ifid_pc);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 0; exp_pc[1] = 4; exp_pc[2] = 8; exp_pc[3] = 12;
    tick(0, 1, 0, 0);
    checks++;
    if (pc_out !== 0 || ifid_valid !== 0) begin
      errors++;
      $display("FAIL boot: pc=%h v=%b want pc=0 v=0", pc_out, ifid_valid);
    end
    tick(0, 0, 0, 0);
    checks++;
    if (ifid_valid !== 1 || ifid_pc !== 0 || ifid_inst !== 32'h1000_0000 ||
        ifid_pc4 !== 4 || pc_out !== 4 || fetch_count !== 1) begin
      errors++;
      $display("FAIL first_fetch: v=%b ipc=%h inst=%h pc4=%h pc=%h cnt=%0d",
               ifid_valid, ifid_pc, ifid_inst, ifid_pc4, pc_out, fetch_count);
    end
    tick(0, 0, 0, 0);
    checks++;
    if (pc_out !== exp_pc[2] || ifid_pc !== exp_pc[1] || fetch_count !== 2) begin
      errors++;
      $display("FAIL second_fetch: pc=%h ipc=%h cnt=%0d want 8 4 2",
               pc_out, ifid_pc, fetch_count);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0);
      checks++;
      if (pc_out !== 8 || ifid_pc !== 4 || ifid_valid !== 1 ||
          fetch_count !== 2) begin
        errors++;
        $display("FAIL stall[%0d]: pc=%h ipc=%h v=%b cnt=%0d want 8 4 1 2",
                 i, pc_out, ifid_pc, ifid_valid, fetch_count);
      end
    end
    tick(0, 0, 0, 0);
    checks++;
    if (ifid_pc !== 8 || ifid_inst !== 32'h1000_0002 || pc_out !== 12 ||
        fetch_count !== 3) begin
      errors++;
      $display("FAIL stall_resume: ipc=%h inst=%h pc=%h cnt=%0d",
               ifid_pc, ifid_inst, pc_out, fetch_count);
    end
  endtask

  task automatic test_redirect_stall();
    tick(0, 1, 1, 32'h40);
    checks++;
    if (ifid_valid !== 0 || pc_out !== 32'h40 || ifid_pc !== 8) begin
      errors++;
      $display("FAIL redir_bubble: v=%b pc=%h ipc=%h want 0 40 8",
               ifid_valid, pc_out, ifid_pc);
    end
    tick(0, 0, 0, 0);
    checks++;
    if (ifid_valid !== 1 || ifid_pc !== 32'h40 ||
        ifid_inst !== 32'h1000_0010 || pc_out !== 32'h44) begin
      errors++;
      $display("FAIL redir_fetch: v=%b ipc=%h inst=%h pc=%h",
               ifid_valid, ifid_pc, ifid_inst, pc_out);
    end
  endtask

  task automatic test_misalign();
    tick(0, 0, 1, 32'h42);
    checks++;
    if (pc_out !== 32'h40 || misalign_err !== 1) begin
      errors++;
      $display("FAIL misalign: pc=%h mis=%b want 40 1", pc_out, misalign_err);
    end
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 0);
    tick(0, 0, 1, 32'h10);
    checks++;
    if (misalign_err !== 1 || pc_out !== 32'h10) begin
      errors++;
      $display("FAIL misalign_sticky: mis=%b pc=%h want 1 10",
               misalign_err, pc_out);
    end
    tick(1, 0, 0, 0);
    checks++;
    if (misalign_err !== 0 || pc_out !== 0) begin
      errors++;
      $display("FAIL misalign_clear: mis=%b pc=%h want 0 0",
               misalign_err, pc_out);
    end
  endtask

  task automatic test_wrap();
    tick(0, 0, 1, 32'd252);
    tick(0, 0, 0, 0);
    checks++;
    if (pc_out !== 0 || ifid_pc !== 252 || ifid_pc4 !== 256 ||
        ifid_inst !== 32'h1000_003F) begin
      errors++;
      $display("FAIL wrap: pc=%h ipc=%0d pc4=%0d inst=%h want 0 252 256",
               pc_out, ifid_pc, ifid_pc4, ifid_inst);
    end
  endtask

  task automatic test_halt();
    int  n;
    logic seen;
    load_ramp();
    mem[5] = HALT;
    tick(1, 0, 0, 0);
    seen = 0; n = 0;
    while (!seen && n < 20) begin
      tick(0, 0, 0, 0);
      n++;
      if (ifid_valid && ifid_pc == 20) seen = 1;
    end
    checks++;
    if (!seen || ifid_inst !== HALT || pc_out !== 20 || halted !== 1) begin
      errors++;
      $display("FAIL halt_entry: seen=%b inst=%h pc=%h halted=%b",
               seen, ifid_inst, pc_out, halted);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, i[0], 0, 0);
      checks++;
      if (halted !== 1 || ifid_valid !== 0 || pc_out !== 20 ||
          fetch_count !== 6) begin
        errors++;
        $display("FAIL halt_hold[%0d]: h=%b v=%b pc=%h cnt=%0d want 1 0 14 6",
                 i, halted, ifid_valid, pc_out, fetch_count);
      end
    end
    tick(0, 0, 1, 0);
    checks++;
    if (halted !== 0 || pc_out !== 0 || ifid_valid !== 0) begin
      errors++;
      $display("FAIL halt_exit: h=%b pc=%h v=%b want 0 0 0",
               halted, pc_out, ifid_valid);
    end
    tick(0, 0, 0, 0);
    checks++;
    if (ifid_valid !== 1 || ifid_pc !== 0 || pc_out !== 4) begin
      errors++;
      $display("FAIL halt_resume: v=%b ipc=%h pc=%h want 1 0 4",
               ifid_valid, ifid_pc, pc_out);
    end
  endtask

  task automatic test_random();
    logic        r, s, rv;
    logic [31:0] t;
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    tick(1, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 9) == 0);
      t  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      tick(r, s, rv, t);
      checks++;
      if (pc_out !== m_pc || ifid_valid !== m_v || ifid_pc !== m_ipc ||
          ifid_pc4 !== m_ipc4 || ifid_inst !== m_inst ||
          halted !== m_halt || misalign_err !== m_mis ||
          fetch_count !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL random[%0d]: pc=%h/%h v=%b/%b ipc=%h/%h pc4=%h/%h inst=%h/%h h=%b/%b mis=%b/%b cnt=%0d/%0d",
                 c, pc_out, m_pc, ifid_valid, m_v, ifid_pc, m_ipc,
                 ifid_pc4, m_ipc4, ifid_inst, m_inst, halted, m_halt,
                 misalign_err, m_mis, fetch_count, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_misalign();
    test_wrap();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
